// File: rtl/seg_scan_rx.sv
// seg_scan_rx: recovers six decoded digits from a scanned seven-segment bus.
// A frame is published only when every digit has been captured since the last one.
module seg_scan_rx #(
  parameter int STABLE_CNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_valid,
  output logic        o_frame_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam logic [15:0] LAST = 16'(STABLE_CNT - 1);
  localparam logic [13:0] BUS_RST = {6'h3f, 8'h00};
  state_t state_q, state_d;
  logic [13:0] sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] shadow_q, shadow_d, digits_q, digits_d;
  logic [5:0]  shadow_dp_q, shadow_dp_d, seen_q, seen_d, seen_n, dp_q, dp_d, sel, enb;
  logic        pend_q, pend_d, pend_n, valid_q, valid_d, err_q, err_d;
  logic        changed, fire, one_hot, done, dp;
  logic [6:0]  seg;
  logic [3:0]  code;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h7e:   decode = 4'h0;
      7'h30:   decode = 4'h1;
      7'h6d:   decode = 4'h2;
      7'h79:   decode = 4'h3;
      7'h33:   decode = 4'h4;
      7'h5b:   decode = 4'h5;
      7'h5f:   decode = 4'h6;
      7'h70:   decode = 4'h7;
      7'h7f:   decode = 4'h8;
      7'h73:   decode = 4'h9;
      7'h00:   decode = 4'hf;
      default: decode = 4'he;
    endcase
  endfunction

  assign enb = sync2_q[13:8];
  assign seg = sync2_q[7:1];
  assign dp  = sync2_q[0];

  always_comb begin
    changed = sync2_q != prev_q;
    cnt_d = changed ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + 16'd1);
    sel = ~enb;
    one_hot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    code = decode(seg);
    // A change on the would-be capture cycle suppresses the capture.
    fire = !changed && state_q == SETTLE && cnt_d == LAST;
    state_d = changed ? (enb == 6'h3f ? IDLE : SETTLE) : (fire ? HELD : state_q);
    shadow_d = shadow_q;
    shadow_dp_d = shadow_dp_q;
    seen_n = seen_q;
    pend_n = pend_q | (fire && (!one_hot || code == 4'he));
    if (fire && one_hot) begin
      for (int i = 0; i < 6; i++)
        if (sel[i]) begin
          shadow_d[4*i +: 4] = code;
          shadow_dp_d[i] = dp;
        end
      seen_n = seen_q | sel;
    end
    done = fire && one_hot && seen_n == 6'h3f;
    seen_d = done ? 6'd0 : seen_n;
    pend_d = done ? 1'b0 : pend_n;
    digits_d = done ? shadow_d : digits_q;
    dp_d = done ? shadow_dp_d : dp_q;
    err_d = done ? pend_n : err_q;
    valid_d = done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= BUS_RST;
      sync2_q     <= BUS_RST;
      prev_q      <= BUS_RST;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '1;
      shadow_dp_q <= '0;
      seen_q      <= '0;
      pend_q      <= 1'b0;
      digits_q    <= '1;
      dp_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= {i_seg_enb, i_seg, i_seg_dp};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign o_digits      = digits_q;
  assign o_dp          = dp_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
endmodule
